// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t       : controller state encoding (IDLE, SHIFT, DONE)
//   DEFAULT_WIDTH : default operand/result width in bits
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor (purely combinational).
//   a, b : minuend and subtrahend bits
//   bin  : borrow into this bit position
//   diff : a - b - bin, modulo 2
//   bout : borrow out of this bit position
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a outright, or when they are equal and a borrow
  // is already pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b - bin) mod 2^WIDTH,
// bout = 1 when a < b + bin. One bit is processed per clock, LSB first.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : operand handshake (a, b, bin)
//   a, b, bin           : unsigned minuend, subtrahend, borrow-in
//   out_valid/out_ready : result handshake (diff, bout)
//   diff, bout          : difference and borrow-out
//   dbg_state           : current controller state, for observation only
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 exactly in IDLE and out_valid is 1 exactly in DONE,
// so a result handshake and an operand accept can never share an edge.
// Both are decoded from the state register only, so no input reaches any
// output combinationally. diff/bout hold the last result until the next
// operation completes.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output state_t           dbg_state
);

  // Smallest counter that can hold the value WIDTH.
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;
  logic             br;
  logic [CNT_W-1:0] cnt;
  logic             d_bit;
  logic             br_nx;
  logic             last_bit;

  full_subtractor u_fs (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .bin  (br),
    .diff (d_bit),
    .bout (br_nx)
  );

  // The edge that processes bit WIDTH-1 is the final SHIFT edge.
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = SHIFT;
      SHIFT:   if (last_bit)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      br     <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            br   <= bin;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          // New bits enter at the MSB so after WIDTH edges bit 0 sits at
          // position 0.
          acc  <= {d_bit, acc[WIDTH-1:1]};
          br   <= br_nx;
          cnt  <= cnt + 1'b1;
          // The visible result only changes on completion, so an aborted
          // operation never exposes partial bits.
          if (last_bit) begin
            diff_q <= {d_bit, acc[WIDTH-1:1]};
            bout_q <= br_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             bin = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] diff;
  logic             bout;
  serial_sub_pkg::state_t dbg_state;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Transaction-level view: a result {bout,diff} = a - b - bin computed
  // with one extra bit, due WIDTH edges after the accept edge, retired on
  // the first edge with out_ready while it is due.
  logic [WIDTH:0] exp_q[$];
  bit             m_pending = 1'b0;
  int             m_age = 0;
  logic [WIDTH:0] m_last = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending = 1'b0;
      m_age     = 0;
      m_last    = '0;
      exp_q.delete();
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending = 1'b1;
        m_age     = 0;
        exp_q.push_back({1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin});
      end
    end else if (m_age < WIDTH) begin
      m_age++;
    end else if (out_ready) begin
      m_last    = exp_q.pop_front();
      m_pending = 1'b0;
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("m_in_ready", in_ready, !m_pending);
      check("m_out_valid", out_valid, m_pending && m_age == WIDTH);
      if (m_pending && m_age == WIDTH) begin
        if (exp_q.size() == 0) begin
          check("m_queue_empty", 0, 1);
        end else begin
          check("m_diff", diff, exp_q[0][WIDTH-1:0]);
          check("m_bout", bout, exp_q[0][WIDTH]);
        end
      end else if (!m_pending) begin
        check("m_idle_diff", diff, m_last[WIDTH-1:0]);
        check("m_idle_bout", bout, m_last[WIDTH]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge with the block idle.
  task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                       input logic tbin, input logic [WIDTH-1:0] ed,
                       input logic eb, input int hold, input bit noisy);
    bit seen;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    bin       = tbin;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      if (noisy) begin
        in_valid = 1'($urandom_range(0, 1));
        a        = WIDTH'($urandom_range(0, 255));
        b        = WIDTH'($urandom_range(0, 255));
        bin      = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      if (out_valid) begin
        seen = 1'b1;
        check("latency", n, WIDTH);
      end
    end
    if (!seen) check("valid_timeout", 0, 1);
    check("diff", diff, ed);
    check("bout", bout, eb);
    for (int h = 0; h < hold; h++) begin
      if (noisy) begin
        in_valid = ~in_valid;
        a        = WIDTH'($urandom_range(0, 255));
      end
      @(posedge clk); #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_diff", diff, ed);
      check("hold_bout", bout, eb);
    end
    out_ready = 1'b1;
    if (noisy) in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("post_in_ready", in_ready, 1);
    check("post_out_valid", out_valid, 0);
    check("post_diff", diff, ed);
  endtask

  // Accept an operation, then pulse reset during its third SHIFT cycle.
  task automatic reset_mid_shift();
    in_valid = 1'b1;
    a        = 8'h3C;
    b        = 8'h11;
    bin      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_diff", diff, 0);
    check("rst_bout", bout, 0);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_diff", diff, 0);
    check("reset_bout", bout, 0);
    rst    = 1'b0;
    chk_en = 1'b1;

    do_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 2, 1'b0);
    do_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1, 1'b0);
    do_op(8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 5, 1'b1);
    reset_mid_shift();
    do_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 0, 1'b0);
    do_op(8'h03, 8'h05, 1'b1, 8'hFD, 1'b1, 0, 1'b0);
    do_op(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1, 1'b0);
    do_op(8'h01, 8'h00, 1'b1, 8'h00, 1'b0, 0, 1'b0);
    do_op(8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 0, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
